// File: rtl/washer_motor_drive.sv
// washer_motor_drive: H-bridge gate driver for the washer drum motor.
// Turns forward/reverse level commands into four gate signals, inserts
// dead-time on every drive-state change, ramps the PWM duty on start-up and
// latches a fault on an illegal command pair or an emergency stop.
module washer_motor_drive #(
  parameter int DEAD_CYC  = 4,
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fwd_cmd,
  input  logic       rev_cmd,
  input  logic       estop_n,
  input  logic       fault_clr,
  output logic       hs_a,
  output logic       ls_a,
  output logic       hs_b,
  output logic       ls_b,
  output logic       at_speed,
  output logic       fault,
  output logic [2:0] drv_state
);

  localparam int                DW        = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0]     DEAD_LOAD = DW'(DEAD_CYC - 1);
  localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS+1:0] STEP_W  = (PWM_BITS + 2)'(RAMP_STEP);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEAD  = 3'd1,
    ST_FWD   = 3'd2,
    ST_REV   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_FWD  = 2'd1,
    REQ_REV  = 2'd2,
    REQ_ILL  = 2'd3
  } req_e;

  state_e                state_q, state_d;
  req_e                  target_q, target_d;
  req_e                  req;
  logic [DW-1:0]         dead_cnt_q, dead_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS:0]     duty_q, duty_d;
  logic [PWM_BITS+1:0]   duty_sum;
  logic                  pwm_on;
  logic                  estop_meta_q, estop_sync_q, estop;
  logic                  hs_a_q, hs_a_d, ls_a_q, ls_a_d;
  logic                  hs_b_q, hs_b_d, ls_b_q, ls_b_d;
  logic                  at_speed_q, at_speed_d, fault_q, fault_d;

  function automatic state_e req_to_state(input req_e r);
    case (r)
      REQ_FWD: return ST_FWD;
      REQ_REV: return ST_REV;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic conducting(input state_e s);
    return (s == ST_FWD) || (s == ST_REV);
  endfunction

  // Two-flop synchronizer for the asynchronous emergency stop; resets to "not stopped"
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estop_meta_q <= 1'b1;
      estop_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let both stages sample their inputs
      // from before the edge, so this really is a two-stage pipeline.
      estop_meta_q <= estop_n;
      estop_sync_q <= estop_meta_q;
    end
  end

  assign estop = ~estop_sync_q;

  // Decode the raw command pair into a requested mode
  always_comb begin
    case ({fwd_cmd, rev_cmd})
      2'b10:   req = REQ_FWD;
      2'b01:   req = REQ_REV;
      2'b11:   req = REQ_ILL;
      default: req = REQ_IDLE;
    endcase
  end

  // Next drive state, dead-time target and dead-time counter
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    target_d   = target_q;
    dead_cnt_d = dead_cnt_q;
    if (estop || (req == REQ_ILL)) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((req == REQ_FWD) || (req == REQ_REV)) begin
            state_d    = ST_DEAD;
            target_d   = req;
            dead_cnt_d = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (req != target_q) begin
            target_d   = req;
            dead_cnt_d = DEAD_LOAD;
          end else if (dead_cnt_q == '0) begin
            state_d = req_to_state(target_q);
          end else begin
            dead_cnt_d = dead_cnt_q - DW'(1);
          end
        end
        ST_FWD, ST_REV: begin
          if (req_to_state(req) != state_q || req == REQ_IDLE) begin
            state_d    = ST_DEAD;
            target_d   = req;
            dead_cnt_d = DEAD_LOAD;
          end
        end
        ST_FAULT: begin
          if (fault_clr && (req == REQ_IDLE)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // PWM counter and soft-start duty; both restart whenever conduction (re)starts
  always_comb begin
    duty_sum  = {1'b0, duty_q} + STEP_W;
    pwm_cnt_d = '0;
    duty_d    = '0;
    if (conducting(state_d) && (state_d == state_q)) begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      duty_d    = duty_q;
      if (&pwm_cnt_q) begin
        duty_d = (duty_sum >= {1'b0, DUTY_FULL}) ? DUTY_FULL : duty_sum[PWM_BITS:0];
      end
    end
  end

  // Gate and status decode from the next state so the registered outputs line up with drv_state
  always_comb begin
    pwm_on     = ({1'b0, pwm_cnt_d} < duty_d);
    hs_a_d     = (state_d == ST_FWD) && pwm_on;
    ls_b_d     = (state_d == ST_FWD);
    hs_b_d     = (state_d == ST_REV) && pwm_on;
    ls_a_d     = (state_d == ST_REV);
    at_speed_d = conducting(state_d) && (duty_d == DUTY_FULL);
    fault_d    = (state_d == ST_FAULT);
  end

  // All drive state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      target_q   <= REQ_IDLE;
      dead_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      hs_a_q     <= 1'b0;
      ls_a_q     <= 1'b0;
      hs_b_q     <= 1'b0;
      ls_b_q     <= 1'b0;
      at_speed_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      dead_cnt_q <= dead_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      hs_a_q     <= hs_a_d;
      ls_a_q     <= ls_a_d;
      hs_b_q     <= hs_b_d;
      ls_b_q     <= ls_b_d;
      at_speed_q <= at_speed_d;
      fault_q    <= fault_d;
    end
  end

  assign hs_a      = hs_a_q;
  assign ls_a      = ls_a_q;
  assign hs_b      = hs_b_q;
  assign ls_b      = ls_b_q;
  assign at_speed  = at_speed_q;
  assign fault     = fault_q;
  assign drv_state = state_q;

endmodule

// File: tb/tb_washer_motor_drive.sv
// tb_washer_motor_drive: self-checking bench for washer_motor_drive.
// A behavioural model (cycles-since-entry view of the PWM ramp) feeds a
// scoreboard queue on every driven cycle; a vector table and hand-written
// sequences add explicit expectations for the directed scenarios.
module tb_washer_motor_drive;

  localparam int DEAD_CYC  = 4;
  localparam int PWM_BITS  = 4;
  localparam int RAMP_STEP = 4;
  localparam int PERIOD    = 2 ** PWM_BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_cmd, rev_cmd, estop_n, fault_clr;
  logic       hs_a, ls_a, hs_b, ls_b, at_speed, fault;
  logic [2:0] drv_state;

  int n_checks = 0;
  int n_err    = 0;

  washer_motor_drive #(
    .DEAD_CYC (DEAD_CYC),
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fwd_cmd  (fwd_cmd),
    .rev_cmd  (rev_cmd),
    .estop_n  (estop_n),
    .fault_clr(fault_clr),
    .hs_a     (hs_a),
    .ls_a     (ls_a),
    .hs_b     (hs_b),
    .ls_b     (ls_b),
    .at_speed (at_speed),
    .fault    (fault),
    .drv_state(drv_state)
  );

  always #5 clk = ~clk;

  // Observed bundle: {drv_state, hs_a, ls_a, hs_b, ls_b, at_speed, fault}
  function automatic logic [8:0] obs();
    return {drv_state, hs_a, ls_a, hs_b, ls_b, at_speed, fault};
  endfunction

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp, input logic [8:0] mask);
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (mask %b) at %0t", name, act, exp, mask, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_target, m_dead, m_age;
  bit m_s1, m_s2;

  function automatic void model_reset();
    m_state = 0; m_target = 0; m_dead = 0; m_age = 0;
    m_s1 = 1'b1; m_s2 = 1'b1;
  endfunction

  function automatic void model_step(input bit f, input bit r, input bit e, input bit c);
    bit est;
    int req;
    est  = !m_s2;
    m_s2 = m_s1;
    m_s1 = e;
    req  = (f && !r) ? 2 : ((r && !f) ? 3 : 0);
    if (est || (f && r)) begin
      m_state = 4;
    end else begin
      case (m_state)
        0: if (req != 0) begin m_state = 1; m_target = req; m_dead = DEAD_CYC; end
        1: begin
          if (req != m_target) begin
            m_target = req; m_dead = DEAD_CYC;
          end else begin
            m_dead--;
            if (m_dead == 0) begin m_state = m_target; m_age = 0; end
          end
        end
        2, 3: begin
          if (req != m_state) begin m_state = 1; m_target = req; m_dead = DEAD_CYC; end
          else m_age++;
        end
        default: if (c && req == 0) m_state = 0;
      endcase
    end
  endfunction

  function automatic logic [8:0] model_out();
    int  duty;
    bit  pwm, cond;
    duty = RAMP_STEP * (m_age / PERIOD);
    if (duty > PERIOD) duty = PERIOD;
    pwm  = (m_age % PERIOD) < duty;
    cond = (m_state == 2) || (m_state == 3);
    return {3'(m_state), (m_state == 2) && pwm, m_state == 3, (m_state == 3) && pwm,
            m_state == 2, cond && (duty == PERIOD), m_state == 4};
  endfunction

  // ---------------- scoreboard-driven cycle step ----------------
  logic [8:0] sb_q[$];

  task automatic step(input logic f, input logic r, input logic e, input logic c);
    logic [8:0] exp;
    fwd_cmd = f; rev_cmd = r; estop_n = e; fault_clr = c;
    model_step(f, r, e, c);
    sb_q.push_back(model_out());
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    check("scoreboard", obs(), exp, 9'h1FF);
    check("gate_invariant", {6'b0, hs_a & ls_a, hs_b & ls_b, hs_a & hs_b}, 9'h000, 9'h1FF);
  endtask

  // Asserts reset away from any clock edge, checks outputs cleared at once, then releases
  task automatic apply_reset(input string name);
    rst = 1'b0;
    fwd_cmd = 1'b0; rev_cmd = 1'b0; estop_n = 1'b1; fault_clr = 1'b0;
    model_reset();
    #1;
    check(name, obs(), 9'h000, 9'h1FF);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       f, r, e, c;
    int         reps;
    logic [8:0] exp, mask;
  } vec_t;

  vec_t vec_q[$];

  // Field value -1 means "not checked"
  function automatic logic [1:0] fld(input int v);
    return (v < 0) ? 2'b00 : {1'b1, v[0]};
  endfunction

  task automatic add_vec(input logic f, input logic r, input logic e, input logic c,
                         input int reps, input int st, input int hsa, input int lsa,
                         input int hsb, input int lsb, input int as, input int flt);
    vec_t v;
    logic [1:0] a, b, d, g, h, k;
    a = fld(hsa); b = fld(lsa); d = fld(hsb); g = fld(lsb); h = fld(as); k = fld(flt);
    v.f = f; v.r = r; v.e = e; v.c = c; v.reps = reps;
    v.exp  = {3'(st), a[0], b[0], d[0], g[0], h[0], k[0]};
    v.mask = {3'b111, a[1], b[1], d[1], g[1], h[1], k[1]};
    vec_q.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    fwd_cmd = 1'b0; rev_cmd = 1'b0; estop_n = 1'b1; fault_clr = 1'b0;
    #1;
    apply_reset("reset_state");

    // Start forward from IDLE: 4 dead cycles, then duty 0/4/8/12 per period, at speed at cycle 69
    for (int i = 0; i < DEAD_CYC; i++) begin
      step(1, 0, 1, 0);
      check($sformatf("start_dead%0d", i), obs(), {3'd1, 6'b000000}, 9'h1FF);
    end
    for (int p = 0; p < 4; p++) begin
      cnt = 0;
      for (int k = 0; k < PERIOD; k++) begin
        step(1, 0, 1, 0);
        cnt += int'(hs_a);
      end
      check($sformatf("duty_period%0d", p), 9'(cnt), 9'(p * RAMP_STEP), 9'h1FF);
    end
    step(1, 0, 1, 0);
    check("at_speed_cycle69", obs(), {3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, 9'h1FF);

    //       f  r  e  c reps st hsa lsa hsb lsb as flt
    add_vec(1, 0, 1, 0,  5, 2,  1,  0,  0,  1,  1, 0); // holding at speed
    add_vec(0, 1, 1, 0,  4, 1,  0,  0,  0,  0,  0, 0); // reverse: dead-time
    add_vec(0, 1, 1, 0, 20, 3,  0,  1, -1,  0,  0, 0); // REV ramping
    add_vec(1, 0, 1, 0,  4, 1,  0,  0,  0,  0,  0, 0); // forward mid-ramp: dead-time
    add_vec(1, 0, 1, 0,  5, 2,  0,  0,  0,  1,  0, 0); // FWD, duty restarted
    add_vec(0, 0, 1, 0,  4, 1,  0,  0,  0,  0,  0, 0); // stop goes through dead-time
    add_vec(0, 0, 1, 0,  2, 0,  0,  0,  0,  0,  0, 0); // IDLE
    add_vec(1, 0, 1, 0,  2, 1,  0,  0,  0,  0,  0, 0); // two cycles into FWD dead-time
    add_vec(0, 1, 1, 0,  4, 1,  0,  0,  0,  0,  0, 0); // REV request restarts dead-time
    add_vec(0, 1, 1, 0,  3, 3,  0,  1,  0,  0,  0, 0); // REV entered
    add_vec(0, 1, 1, 0, 61, 3,  0,  1, -1,  0,  0, 0); // ramp up
    add_vec(0, 1, 1, 0,  3, 3,  0,  1,  1,  0,  1, 0); // at speed in REV
    add_vec(1, 1, 1, 0,  1, 4,  0,  0,  0,  0,  0, 1); // illegal pair -> FAULT
    add_vec(1, 0, 1, 1,  1, 4,  0,  0,  0,  0,  0, 1); // clear ignored, fwd high
    add_vec(0, 1, 1, 1,  1, 4,  0,  0,  0,  0,  0, 1); // clear ignored, rev high
    add_vec(0, 0, 1, 0,  2, 4,  0,  0,  0,  0,  0, 1); // fault stays latched
    add_vec(0, 0, 1, 1,  1, 0,  0,  0,  0,  0,  0, 0); // clear accepted
    add_vec(0, 0, 1, 0,  1, 0,  0,  0,  0,  0,  0, 0);
    add_vec(0, 1, 1, 0,  4, 1,  0,  0,  0,  0,  0, 0);
    add_vec(0, 1, 1, 0,  5, 3,  0,  1,  0,  0,  0, 0);
    add_vec(0, 1, 0, 0,  2, 3,  0,  1,  0,  0,  0, 0); // estop in synchronizer
    add_vec(0, 1, 0, 0,  1, 4,  0,  0,  0,  0,  0, 1); // estop -> FAULT
    add_vec(0, 0, 0, 1,  2, 4,  0,  0,  0,  0,  0, 1); // clear ignored while estop low
    add_vec(0, 0, 1, 0,  2, 4,  0,  0,  0,  0,  0, 1); // estop release still in sync
    add_vec(0, 0, 1, 1,  1, 0,  0,  0,  0,  0,  0, 0); // clear accepted
    add_vec(1, 0, 1, 0,  4, 1,  0,  0,  0,  0,  0, 0);
    add_vec(1, 0, 1, 0, 70, 2, -1,  0,  0,  1, -1, 0); // FWD up to speed

    foreach (vec_q[i]) begin
      for (int n = 0; n < vec_q[i].reps; n++) begin
        step(vec_q[i].f, vec_q[i].r, vec_q[i].e, vec_q[i].c);
        check($sformatf("vec%0d_rep%0d", i, n), obs(), vec_q[i].exp, vec_q[i].mask);
      end
    end

    // Asynchronous reset while driving forward at speed
    check("pre_reset_at_speed", {8'b0, at_speed}, 9'h001, 9'h1FF);
    #2;
    apply_reset("reset_mid_fwd");

    // Asynchronous reset while a fault is latched
    step(1, 1, 1, 0);
    check("illegal_from_idle", obs(), {3'd4, 6'b000001}, 9'h1FF);
    #2;
    apply_reset("reset_in_fault");

    // Random command blocks, checked against the model only
    for (int b = 0; b < 30; b++) begin
      int   mode, len;
      logic f, r, est_low;
      mode    = $urandom_range(0, 9);
      len     = (mode == 9) ? 1 : $urandom_range(1, 90);
      est_low = ($urandom_range(0, 7) == 0);
      f = (mode >= 3 && mode <= 5) || (mode == 9);
      r = (mode >= 6);
      for (int k = 0; k < len; k++) begin
        step(f, r, !est_low, $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/washer_motor_drive.md
Name: washer_motor_drive

Overview:
- H-bridge drive stage for the washer drum motor, at the far end of the controller's forward/reverse motor commands.
- Converts level commands (forward, reverse, none) into four gate signals.
- Enforces dead-time on every direction change, applies a PWM soft-start ramp, and latches faults on an illegal command or emergency stop.
- Reports at-speed and fault status back to the controller and the panel LEDs.

Parameters:
- DEAD_CYC, 4: all-gates-off cycles inserted on every drive-state change (minimum 1).
- PWM_BITS, 8: PWM counter width. PWM period is 2^PWM_BITS cycles.
- RAMP_STEP, 8: duty increment per PWM period during soft-start (minimum 1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- fwd_cmd  in  1  forward request; level, synchronous to clk
- rev_cmd  in  1  reverse request; level, synchronous to clk
- estop_n  in  1  emergency stop, asynchronous, active-low
- fault_clr  in  1  single-cycle pulse that clears a latched fault
- hs_a  out  1  high-side gate, leg A
- ls_a  out  1  low-side gate, leg A
- hs_b  out  1  high-side gate, leg B
- ls_b  out  1  low-side gate, leg B
- at_speed  out  1  duty saturated at 100% in FWD or REV
- fault  out  1  latched fault
- drv_state  out  3  current state encoding: IDLE=0, DEAD=1, FWD=2, REV=3, FAULT=4

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; all gates 0; at_speed=0; fault=0.
  - pwm_cnt=0; duty=0; dead_cnt=0; target=IDLE.
- Input handling:
  - estop_n passes through a 2-flop synchronizer; internal estop is asserted 2 cycles after the falling edge.
  - All other inputs are sampled directly.
- Requested mode:
  - FWD if fwd_cmd=1 and rev_cmd=0.
  - REV if rev_cmd=1 and fwd_cmd=0.
  - IDLE if both are 0.
  - ILLEGAL if both are 1.
- Gate outputs are registered and decoded from state:
  - IDLE, DEAD, FAULT: all four gates 0.
  - FWD: hs_a=pwm, ls_b=1, ls_a=0, hs_b=0.
  - REV: hs_b=pwm, ls_a=1, hs_a=0, ls_b=0.
  - Invariant in every cycle: hs_a&ls_a=0, hs_b&ls_b=0, hs_a&hs_b=0.
- PWM and soft-start:
  - pwm_cnt is PWM_BITS wide, wraps, and is cleared on entry to FWD or REV.
  - duty is PWM_BITS+1 wide, cleared on entry to FWD or REV.
  - pwm = (pwm_cnt < duty).
  - On the cycle where pwm_cnt is all-ones, duty becomes min(duty+RAMP_STEP, 2^PWM_BITS); the new value applies to the next period.
  - at_speed=1 when duty = 2^PWM_BITS and state is FWD or REV; at_speed=0 in every other state.
- State transitions, evaluated each cycle:
  - Priority in any state: internal estop, then ILLEGAL. Either one forces FAULT next cycle and sets fault=1.
  - IDLE: request FWD or REV → DEAD, target=request, dead_cnt=DEAD_CYC-1.
  - DEAD: gates off. If the request differs from target, re-latch target and reload dead_cnt (the dead-time restarts). Otherwise decrement dead_cnt; at dead_cnt=0 → target state.
  - FWD or REV: request different from current state → DEAD, target=request, dead_cnt reloaded. IDLE requests go through DEAD, then IDLE.
  - Gates are therefore 0 for exactly DEAD_CYC cycles between any two conducting states and when stopping.
  - FAULT: exits only when fault_clr=1, estop inactive and requested mode is IDLE, all in the same cycle. Next state is IDLE and fault=0. fault_clr is ignored in all other cases.
- Latency: a command seen in cycle N gives DEAD from N+1 to N+DEAD_CYC, and the conducting state from N+DEAD_CYC+1.
- A reset during any state returns to IDLE immediately with gates 0.

Test Plan (DEAD_CYC=4, PWM_BITS=4, RAMP_STEP=4):
- Start forward: from IDLE, fwd_cmd=1 at cycle 0 → gates 0 for cycles 1-4; ls_b=1 from cycle 5. hs_a duty is 0/16, 4/16, 8/16, 12/16 over successive periods. Then hs_a is constant 1 and at_speed=1 from cycle 69.
- Reverse mid-ramp: in FWD, switch to rev_cmd=1 → all gates 0 for exactly 4 cycles, then ls_a=1. Duty restarts at 0 and at_speed=0. The invariant holds in every cycle.
- Command toggle during DEAD: request REV two cycles into a FWD dead-time → dead-time restarts (4 full cycles) and the block then enters REV.
- Illegal command: fwd_cmd=rev_cmd=1 for 1 cycle while at speed → FAULT next cycle, fault=1, all gates 0. fault_clr while a command is still high is ignored. fault_clr with both commands low → IDLE, fault=0.
- Emergency stop: estop_n low in REV → FAULT 2-3 cycles later with gates 0. fault_clr while estop_n is still low has no effect.
- Reset: rst low mid-FWD → gates, at_speed and fault are 0 asynchronously, and drv_state=0.
